systolic_seq_ctrl: RTL



---
 rtl/systolic_pkg.sv | 24 ++
 rtl/systolic_skew_sel.sv | 25 ++
 rtl/systolic_seq_ctrl.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared constants, state encoding and element indexing for the 3x3 systolic sequencer.
package systolic_pkg;

  localparam int DATA_W   = 32;
  localparam int DIM      = 3;
  localparam int FEED_LEN = 2 * DIM - 1;
  localparam int MAT_W    = DIM * DIM * DATA_W;
  localparam int VEC_W    = DIM * DATA_W;
  localparam int CNT_W    = 8;

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    FEED,
    DRAIN,
    DONE
  } state_t;

  // Row-major position of element (i,j) inside a flat matrix bus.
  function automatic int elem_idx(input int i, input int j);
    return i * DIM + j;
  endfunction

endpackage

// File: rtl/systolic_skew_sel.sv
// Picks the element a skewed lane presents at a given feed step, or zero outside its window.
module systolic_skew_sel
  import systolic_pkg::*;
(
  input  logic [1:0]        lane,
  input  logic [CNT_W-1:0]  step,
  input  logic [VEC_W-1:0]  vec,
  output logic [DATA_W-1:0] elem
);

  logic [CNT_W-1:0] lane_ext;
  logic [CNT_W-1:0] offset;

  assign lane_ext = {{(CNT_W-2){1'b0}}, lane};
  assign offset   = step - lane_ext;

  always_comb begin
    elem = '0;
    // Lane k starts k steps late and then walks its vector once.
    if (step >= lane_ext && offset < CNT_W'(DIM)) begin
      elem = vec[int'(offset[1:0]) * DATA_W +: DATA_W];
    end
  end

endmodule

// File: rtl/systolic_seq_ctrl.sv
// Sequencer for the 3x3 output-stationary systolic array: latch operands, clear,
// feed skewed row/column streams, wait out the pipeline, then hold the captured result.
module systolic_seq_ctrl
  import systolic_pkg::*;
#(
  parameter int DRAIN_CYCLES = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start_valid,
  output logic              start_ready,
  input  logic [MAT_W-1:0]  a_mat,
  input  logic [MAT_W-1:0]  b_mat,
  output logic              array_rst_n,
  output logic [DATA_W-1:0] W0,
  output logic [DATA_W-1:0] W1,
  output logic [DATA_W-1:0] W2,
  output logic [DATA_W-1:0] N0,
  output logic [DATA_W-1:0] N1,
  output logic [DATA_W-1:0] N2,
  input  logic [DATA_W-1:0] out0_0,
  input  logic [DATA_W-1:0] out0_1,
  input  logic [DATA_W-1:0] out0_2,
  input  logic [DATA_W-1:0] out1_0,
  input  logic [DATA_W-1:0] out1_1,
  input  logic [DATA_W-1:0] out1_2,
  input  logic [DATA_W-1:0] out2_0,
  input  logic [DATA_W-1:0] out2_1,
  input  logic [DATA_W-1:0] out2_2,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [MAT_W-1:0]  c_mat,
  output logic              busy
);

  localparam logic [CNT_W-1:0] FEED_LAST  = CNT_W'(FEED_LEN - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYCLES - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next, cnt_inc;
  logic [MAT_W-1:0]  a_reg, b_reg, c_reg;
  logic [MAT_W-1:0]  out_flat;
  logic              array_rst_n_reg, array_rst_n_next;
  logic              feed_next;
  logic [DATA_W-1:0] w_reg [DIM];
  logic [DATA_W-1:0] n_reg [DIM];
  logic [DATA_W-1:0] w_sel [DIM];
  logic [DATA_W-1:0] n_sel [DIM];
  logic [VEC_W-1:0]  row_vec [DIM];
  logic [VEC_W-1:0]  col_vec [DIM];

  assign cnt_inc = (cnt_reg == '1) ? cnt_reg : cnt_reg + CNT_W'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (start_valid) begin
          state_next = CLEAR;
          cnt_next   = '0;
        end
      end
      CLEAR: begin
        state_next = FEED;
        cnt_next   = '0;
      end
      FEED: begin
        if (cnt_reg == FEED_LAST) begin
          state_next = DRAIN;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DRAIN: begin
        if (cnt_reg == DRAIN_LAST) begin
          state_next = DONE;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt_inc;
        end
      end
      DONE: begin
        if (res_ready) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  // Stream and clear outputs are registered, so decode them from the upcoming state.
  always_comb begin
    feed_next        = (state_next == FEED);
    array_rst_n_next = (state_next != CLEAR);
  end

  assign start_ready = (state_reg == IDLE);
  assign busy        = (state_reg != IDLE);
  assign res_valid   = (state_reg == DONE);

  always_comb begin
    for (int k = 0; k < DIM; k++) begin
      row_vec[k] = '0;
      col_vec[k] = '0;
      for (int e = 0; e < DIM; e++) begin
        row_vec[k][e*DATA_W +: DATA_W] = a_reg[elem_idx(k, e)*DATA_W +: DATA_W];
        col_vec[k][e*DATA_W +: DATA_W] = b_reg[elem_idx(e, k)*DATA_W +: DATA_W];
      end
    end
  end

  for (genvar gi = 0; gi < DIM; gi++) begin : g_lane
    systolic_skew_sel u_west (
      .lane (2'(gi)),
      .step (cnt_next),
      .vec  (row_vec[gi]),
      .elem (w_sel[gi])
    );
    systolic_skew_sel u_north (
      .lane (2'(gi)),
      .step (cnt_next),
      .vec  (col_vec[gi]),
      .elem (n_sel[gi])
    );
  end

  assign out_flat = {out2_2, out2_1, out2_0, out1_2, out1_1, out1_0, out0_2, out0_1, out0_0};

  always_ff @(posedge clk) begin
    if (reset) begin
      a_reg           <= '0;
      b_reg           <= '0;
      c_reg           <= '0;
      array_rst_n_reg <= 1'b0;
      for (int k = 0; k < DIM; k++) begin
        w_reg[k] <= '0;
        n_reg[k] <= '0;
      end
    end else begin
      array_rst_n_reg <= array_rst_n_next;
      if (state_reg == IDLE && start_valid) begin
        a_reg <= a_mat;
        b_reg <= b_mat;
      end
      for (int k = 0; k < DIM; k++) begin
        w_reg[k] <= feed_next ? w_sel[k] : '0;
        n_reg[k] <= feed_next ? n_sel[k] : '0;
      end
      // Accumulators are final on the last drain edge.
      if (state_reg == DRAIN && cnt_reg == DRAIN_LAST) begin
        c_reg <= out_flat;
      end
    end
  end

  assign array_rst_n = array_rst_n_reg;
  assign c_mat       = c_reg;
  assign W0          = w_reg[0];
  assign W1          = w_reg[1];
  assign W2          = w_reg[2];
  assign N0          = n_reg[0];
  assign N1          = n_reg[1];
  assign N2          = n_reg[2];

endmodule
